// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential radix-4 Booth multiplier.
package mult_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic signed [2:0] booth_digit_t;

endpackage

// File: rtl/booth_rec4.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier window {b[2k+1], b[2k], b[2k-1]}
// onto a digit in {-2,-1,0,+1,+2}.
module booth_rec4
  import mult_pkg::*;
(
  input  logic [2:0]   win_i,
  output booth_digit_t digit_o
);

  always_comb begin
    digit_o = 3'sb000;
    unique case (win_i)
      3'b001, 3'b010: digit_o = 3'sb001;
      3'b011:         digit_o = 3'sb010;
      3'b100:         digit_o = 3'sb110;
      3'b101, 3'b110: digit_o = 3'sb111;
      default:        digit_o = 3'sb000;
    endcase
  end

endmodule

// File: rtl/mult_seq_booth.sv
// Sequential radix-4 Booth multiplier, one digit per cycle, valid/ready handshake.
// Signed operand support is built only when MULT_SEQ_SIGNED_EN is defined.
module mult_seq_booth
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               busy
);

  localparam int PW = 2*WIDTH + 2;
  localparam int BW = WIDTH + 2;
  localparam int ND = WIDTH/2 + 1;
  localparam int CW = $clog2(ND + 1);

  state_t             state_q;
  logic [PW-1:0]      acc_q, acc_d;
  logic [PW-1:0]      mcand_q;
  logic [BW-1:0]      mplier_q;
  logic               prev_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] out_q;
  logic               out_valid_q, busy_q, in_ready_q;

  logic               sgn;
  logic [PW-1:0]      a_ext;
  logic [BW-1:0]      b_ext;
  logic [PW-1:0]      term;
  booth_digit_t       digit;

`ifdef MULT_SEQ_SIGNED_EN
  assign sgn = is_signed;
`else
  assign sgn = is_signed & 1'b0;
`endif

  // Two extra bits on the multiplier give the zero-extended unsigned case a
  // positive top digit, so one Booth sweep covers both modes.
  assign a_ext = {{(PW-WIDTH){sgn & a[WIDTH-1]}}, a};
  assign b_ext = {{2{sgn & b[WIDTH-1]}}, b};

  booth_rec4 u_rec (
    .win_i   ({mplier_q[1:0], prev_q}),
    .digit_o (digit)
  );

  always_comb begin
    term = '0;
    unique case (digit)
      3'sb001: term = mcand_q;
      3'sb010: term = mcand_q << 1;
      3'sb111: term = -mcand_q;
      3'sb110: term = -(mcand_q << 1);
      default: term = '0;
    endcase
    acc_d = acc_q + term;
  end

  // The multiplicand shifts up by two each cycle, so the 4^k weight is implicit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      prev_q      <= 1'b0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            mcand_q    <= a_ext;
            mplier_q   <= b_ext;
            prev_q     <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b0;
            state_q    <= CALC;
          end
        end
        CALC: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 2;
          mplier_q <= mplier_q >> 2;
          prev_q   <= mplier_q[1];
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == CW'(ND-1)) begin
            out_q       <= acc_d[2*WIDTH-1:0];
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out       = out_q;

endmodule

// File: tb/tb_mult_seq_booth.sv
// Self-checking bench for mult_seq_booth: directed corner cases on a 32-bit
// instance plus a randomized sweep across 4-, 16- and 32-bit instances.
module tb_mult_seq_booth;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic isSigned = 1'b0;

  logic        inValid32 = 1'b0, outReady32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        inReady32, outValid32, busy32;
  logic [63:0] out32;

  logic        inValid16 = 1'b0, outReady16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        inReady16, outValid16, busy16;
  logic [31:0] out16;

  logic        inValid4 = 1'b0, outReady4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        inReady4, outValid4, busy4;
  logic [7:0]  out4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_seq_booth #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(inValid32), .in_ready(inReady32),
    .a(a32), .b(b32), .is_signed(isSigned), .out_valid(outValid32),
    .out_ready(outReady32), .out(out32), .busy(busy32));

  mult_seq_booth #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(inValid16), .in_ready(inReady16),
    .a(a16), .b(b16), .is_signed(isSigned), .out_valid(outValid16),
    .out_ready(outReady16), .out(out16), .busy(busy16));

  mult_seq_booth #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(inValid4), .in_ready(inReady4),
    .a(a4), .b(b4), .is_signed(isSigned), .out_valid(outValid4),
    .out_ready(outReady4), .out(out4), .busy(busy4));

  // Exact product of two w-bit operands, reduced to 2*w bits.
  function automatic logic [63:0] refProd(input logic [31:0] av, input logic [31:0] bv,
                                          input logic s, input int w);
    logic [63:0] mask, ea, eb, p;
    logic        eff;
`ifdef MULT_SEQ_SIGNED_EN
    eff = s;
`else
    eff = 1'b0;
`endif
    mask = (64'd1 << w) - 64'd1;
    ea = {32'd0, av} & mask;
    eb = {32'd0, bv} & mask;
    if (eff && av[w-1]) ea = ea | ~mask;
    if (eff && bv[w-1]) eb = eb | ~mask;
    p = ea * eb;
    return p & ((64'd1 << (2*w)) - 64'd1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic startOp32(input logic [31:0] av, input logic [31:0] bv, input logic s);
    int n = 0;
    while (!inReady32 && n < 50) begin tick(); n++; end
    a32 = av; b32 = bv; isSigned = s; inValid32 = 1'b1;
    tick();
    inValid32 = 1'b0;
  endtask

  task automatic waitDone32(output int cycles);
    cycles = 0;
    while (!outValid32 && cycles < 100) begin tick(); cycles++; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if ({inReady32, outValid32, busy32} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL reset_flags: got rdy/vld/busy=%b expected 100", {inReady32, outValid32, busy32});
    end
    checks++;
    if (out32 !== 64'd0) begin
      errors++;
      $display("[TB] FAIL reset_out: got %h expected 0", out32);
    end
  endtask

  task automatic test_unsigned_max();
    int cyc = 0;
    logic [63:0] prevOut;
    logic stableOk = 1'b1, busyOk = 1'b1;
    prevOut = out32;
    startOp32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    while (!outValid32 && cyc < 100) begin
      if (out32 !== prevOut) stableOk = 1'b0;
      if (busy32 !== 1'b1 || inReady32 !== 1'b0) busyOk = 1'b0;
      tick(); cyc++;
    end
    checks++;
    if (cyc != 17) begin
      errors++;
      $display("[TB] FAIL latency: got %0d cycles expected 17", cyc);
    end
    checks++;
    if (!stableOk || !busyOk) begin
      errors++;
      $display("[TB] FAIL calc_hold: got stable=%b busy=%b expected 1 1", stableOk, busyOk);
    end
    checks++;
    if (out32 !== 64'hFFFFFFFE00000001) begin
      errors++;
      $display("[TB] FAIL unsigned_max: got %h expected FFFFFFFE00000001", out32);
    end
    outReady32 = 1'b1; tick(); outReady32 = 1'b0;
  endtask

  task automatic test_signed();
    int cyc;
`ifdef MULT_SEQ_SIGNED_EN
    startOp32(32'h80000000, 32'h80000000, 1'b1);
    waitDone32(cyc);
    checks++;
    if (out32 !== 64'h4000000000000000 || cyc != 17) begin
      errors++;
      $display("[TB] FAIL signed_min: got %h after %0d expected 4000000000000000 after 17", out32, cyc);
    end
    outReady32 = 1'b1; tick(); outReady32 = 1'b0;
    startOp32(32'hFFFFFFFF, 32'h00000003, 1'b1);
    waitDone32(cyc);
    checks++;
    if (out32 !== 64'hFFFFFFFFFFFFFFFD) begin
      errors++;
      $display("[TB] FAIL signed_neg: got %h expected FFFFFFFFFFFFFFFD", out32);
    end
`else
    startOp32(32'hFFFFFFFF, 32'h00000003, 1'b1);
    waitDone32(cyc);
    checks++;
    if (out32 !== 64'h00000002FFFFFFFD || cyc != 17) begin
      errors++;
      $display("[TB] FAIL ignore_signed: got %h after %0d expected 00000002FFFFFFFD after 17", out32, cyc);
    end
`endif
    outReady32 = 1'b1; tick(); outReady32 = 1'b0;
  endtask

  task automatic test_backpressure();
    int cyc;
    logic [63:0] held;
    logic holdOk = 1'b1;
    startOp32(32'h12345678, 32'h9ABCDEF0, 1'b0);
    waitDone32(cyc);
    held = out32;
    checks++;
    if (held !== refProd(32'h12345678, 32'h9ABCDEF0, 1'b0, 32)) begin
      errors++;
      $display("[TB] FAIL bp_first: got %h expected %h", held, refProd(32'h12345678, 32'h9ABCDEF0, 1'b0, 32));
    end
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin a32 = 32'd11; b32 = 32'd13; inValid32 = 1'b1; end
      else inValid32 = 1'b0;
      tick();
      if (out32 !== held || outValid32 !== 1'b1 || inReady32 !== 1'b0) holdOk = 1'b0;
    end
    inValid32 = 1'b0;
    checks++;
    if (!holdOk) begin
      errors++;
      $display("[TB] FAIL bp_hold: got out=%h vld=%b rdy=%b expected %h 1 0", out32, outValid32, inReady32, held);
    end
    outReady32 = 1'b1; tick(); outReady32 = 1'b0;
    tick(); tick();
    checks++;
    if ({inReady32, outValid32, busy32} !== 3'b100 || out32 !== held) begin
      errors++;
      $display("[TB] FAIL bp_release: got rdy/vld/busy=%b out=%h expected 100 %h",
               {inReady32, outValid32, busy32}, out32, held);
    end
    startOp32(32'd11, 32'd13, 1'b0);
    waitDone32(cyc);
    checks++;
    if (out32 !== 64'd143) begin
      errors++;
      $display("[TB] FAIL bp_second: got %0d expected 143", out32);
    end
    outReady32 = 1'b1; tick(); outReady32 = 1'b0;
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    logic sawValid = 1'b0;
    startOp32(32'd5, 32'd7, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if ({inReady32, outValid32, busy32} !== 3'b100 || out32 !== 64'd0) begin
      errors++;
      $display("[TB] FAIL rst_mid: got rdy/vld/busy=%b out=%h expected 100 0",
               {inReady32, outValid32, busy32}, out32);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (outValid32) sawValid = 1'b1;
    end
    checks++;
    if (sawValid) begin
      errors++;
      $display("[TB] FAIL rst_discard: got out_valid=1 expected 0");
    end
    startOp32(32'd6, 32'd7, 1'b0);
    waitDone32(cyc);
    checks++;
    if (out32 !== 64'd42 || cyc != 17) begin
      errors++;
      $display("[TB] FAIL rst_next: got %0d after %0d expected 42 after 17", out32, cyc);
    end
    outReady32 = 1'b1; tick(); outReady32 = 1'b0;
  endtask

  // All three widths run side by side with out_ready held high.
  task automatic test_random_sweep(input int pairs);
    logic [31:0] ra, rb;
    logic [15:0] ra16, rb16;
    logic [3:0]  ra4, rb4;
    logic        rs;
    logic        got4, got16, got32;
    int          n;
    outReady32 = 1'b1; outReady16 = 1'b1; outReady4 = 1'b1;
    for (int p = 0; p < pairs; p++) begin
      n = 0;
      while (!(inReady32 && inReady16 && inReady4) && n < 50) begin tick(); n++; end
      ra = $urandom; rb = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
      if ($urandom_range(0, 7) == 0) rb = 32'hFFFFFFFF;
      ra16 = ra[31:16]; rb16 = rb[31:16];
      ra4 = ra[31:28]; rb4 = rb[31:28];
      rs = 1'($urandom_range(0, 1));
      a32 = ra; b32 = rb; a16 = ra16; b16 = rb16; a4 = ra4; b4 = rb4; isSigned = rs;
      inValid32 = 1'b1; inValid16 = 1'b1; inValid4 = 1'b1;
      tick();
      inValid32 = 1'b0; inValid16 = 1'b0; inValid4 = 1'b0;
      a32 = $urandom; b32 = $urandom; a16 = '0; b16 = '1;
      got4 = 1'b0; got16 = 1'b0; got32 = 1'b0;
      n = 0;
      while (!(got4 && got16 && got32) && n < 40) begin
        if (outValid4 && !got4) begin
          got4 = 1'b1; checks++;
          if ({56'd0, out4} !== refProd({28'd0, ra4}, {28'd0, rb4}, rs, 4)) begin
            errors++;
            $display("[TB] FAIL sweep_w4: a=%h b=%h s=%b got %h expected %h", ra4, rb4, rs, out4,
                     refProd({28'd0, ra4}, {28'd0, rb4}, rs, 4));
          end
        end
        if (outValid16 && !got16) begin
          got16 = 1'b1; checks++;
          if ({32'd0, out16} !== refProd({16'd0, ra16}, {16'd0, rb16}, rs, 16)) begin
            errors++;
            $display("[TB] FAIL sweep_w16: a=%h b=%h s=%b got %h expected %h", ra16, rb16, rs, out16,
                     refProd({16'd0, ra16}, {16'd0, rb16}, rs, 16));
          end
        end
        if (outValid32 && !got32) begin
          got32 = 1'b1; checks++;
          if (out32 !== refProd(ra, rb, rs, 32)) begin
            errors++;
            $display("[TB] FAIL sweep_w32: a=%h b=%h s=%b got %h expected %h", ra, rb, rs, out32,
                     refProd(ra, rb, rs, 32));
          end
        end
        if (!(got4 && got16 && got32)) begin tick(); n++; end
      end
      if (!(got4 && got16 && got32)) begin
        checks++; errors++;
        $display("[TB] FAIL sweep_timeout: got done=%b%b%b expected 111", got4, got16, got32);
      end
      tick();
    end
    outReady32 = 1'b0; outReady16 = 1'b0; outReady4 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_unsigned_max();
    test_signed();
    test_backpressure();
    test_reset_mid();
    test_random_sweep(1500);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
